// File: rtl/crc_share_sched.sv
// rtl/crc_share_sched.sv - round-robin share of one byte-serial CRC engine across NUM_REQ frame sources
module crc_share_sched #(
  parameter int               NUM_REQ = 4,
  parameter int               DATA_W  = 8,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT    = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT = 32'hFFFFFFFF,
  parameter int               ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [CRC_W-1:0]          res_crc,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt;
  logic [CRC_W-1:0]  crc_q;
  logic [CRC_W-1:0]  next_crc;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              any_valid;
  logic [ID_W-1:0]   pick;
  logic [ID_W:0]     cand;
  logic              fb;

  // Only the granted requester's beat is ever looked at.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        cur_data  = req_data[i*DATA_W +: DATA_W];
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
      end
    end
  end

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        pick      = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    next_crc = crc_q;
    fb       = 1'b0;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      fb       = next_crc[CRC_W-1] ^ cur_data[b];
      next_crc = {next_crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state == RUN) && (gnt == ID_W'(i));
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      crc_q   <= INIT;
      res_crc <= '0;
      res_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt   <= pick;
            crc_q <= INIT;
            state <= RUN;
          end
        end
        RUN: begin
          if (cur_valid) begin
            crc_q <= next_crc;
            if (cur_last) begin
              res_crc <= next_crc ^ XOR_OUT;
              res_id  <= gnt;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          // The requester just served drops to lowest priority.
          if (res_ready) begin
            rr_ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_share_sched.sv
// tb/tb_crc_share_sched.sv - directed bench for crc_share_sched
module tb_crc_share_sched;

  localparam int NR = 4;
  localparam logic [31:0] CHECK_VAL = 32'hFC891918;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_crc;
  logic [1:0]    res_id;
  logic          busy;

  crc_share_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0]  fq [NR][$];
  int          gap [NR];
  int          gap_idx [NR];
  logic        gapmode [NR];

  int          cyc = 0;
  logic [NR-1:0] prev_ready;
  logic        prev_res_valid;
  logic [NR-1:0] ready_seen;
  int          grant_id_q[$];
  int          grant_cyc_q[$];
  int          acc_cyc_q[$];
  logic [1:0]  rid_q[$];
  logic [31:0] rcrc_q[$];
  int          first_valid_cyc;
  int          last_beat_cyc;
  int          beats_done;
  int          valid_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc2(input logic [7:0] b0, input logic [7:0] b1);
    logic [31:0] c;
    logic [7:0]  bs [2];
    c = 32'hFFFFFFFF;
    bs[0] = b0;
    bs[1] = b1;
    for (int k = 0; k < 2; k++) begin
      c = c ^ {bs[k], 24'h0};
      for (int j = 0; j < 8; j++)
        c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return ~c;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (fq[i].size() > 0 && gap[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = fq[i][0][7:0];
        req_last[i]        = fq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'hA5;
        req_last[i]        = 1'b1;
      end
    end
  endtask

  task automatic clear_logs();
    grant_id_q.delete(); grant_cyc_q.delete(); acc_cyc_q.delete();
    rid_q.delete(); rcrc_q.delete();
    first_valid_cyc = -1; last_beat_cyc = -1; beats_done = 0; valid_rises = 0;
    ready_seen = '0;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NR; i++) begin
      fq[i].delete(); gap[i] = 0; gap_idx[i] = 0; gapmode[i] = 1'b0;
    end
    drive();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); cyc += 2;
    @(negedge clk);
    rst = 1'b0;
    prev_ready = '0;
    prev_res_valid = 1'b0;
    clear_logs();
  endtask

  task automatic load_seq(input int r, input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    for (int k = 0; k < n; k++) begin
      fq[r].push_back({(k == n - 1), b});
      b = b + 8'd1;
    end
  endtask

  task automatic tick();
    logic [NR-1:0] hs;
    hs = req_valid & req_ready;
    ready_seen |= req_ready;
    if (req_ready != '0 && prev_ready == '0)
      for (int i = 0; i < NR; i++)
        if (req_ready[i]) begin
          grant_id_q.push_back(i);
          grant_cyc_q.push_back(cyc);
        end
    prev_ready = req_ready;
    if (res_valid && !prev_res_valid) begin
      first_valid_cyc = cyc;
      valid_rises++;
    end
    prev_res_valid = res_valid;
    if (res_valid && res_ready) begin
      rid_q.push_back(res_id);
      rcrc_q.push_back(res_crc);
      acc_cyc_q.push_back(cyc);
    end
    for (int i = 0; i < NR; i++)
      if (hs[i]) begin
        beats_done++;
        if (fq[i][0][8]) last_beat_cyc = cyc;
      end
    @(posedge clk); cyc++;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        void'(fq[i].pop_front());
        if (gapmode[i]) begin
          gap[i] = 1 + (gap_idx[i] % 3);
          gap_idx[i]++;
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    drive();
  endtask

  task automatic run_results(input int n, input int budget);
    int k;
    k = 0;
    while (rid_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("res_count", rid_q.size(), n);
  endtask

  initial begin
    int start;
    logic [31:0] exp;
    res_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    rst = 1'b0;
    reset_dut();

    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_crc", res_crc, 0);
    check("rst_res_id", res_id, 0);
    check("rst_req_ready", req_ready, 0);

    // requester 0, "123456789" back-to-back
    load_seq(0, 8'h31, 9);
    drive();
    start = cyc;
    run_results(1, 60);
    check("t1_crc", rcrc_q[0], CHECK_VAL);
    check("t1_id", rid_q[0], 0);
    check("t1_grant_lat", grant_cyc_q[0], start + 1);
    check("t1_res_lat", first_valid_cyc, last_beat_cyc + 1);
    check("t1_thruput", last_beat_cyc - grant_cyc_q[0], 8);

    // requester 2 with 1-3 cycle gaps
    reset_dut();
    gapmode[2] = 1'b1;
    load_seq(2, 8'h31, 9);
    drive();
    run_results(1, 100);
    check("t2_crc", rcrc_q[0], CHECK_VAL);
    check("t2_id", rid_q[0], 2);
    check("t2_ready_mask", ready_seen, 4'b0100);
    gapmode[2] = 1'b0;

    // all four requesters pending from reset
    reset_dut();
    for (int i = 0; i < NR; i++) load_seq(i, 8'(8'h10 * i + 8'h03), 2);
    drive();
    start = cyc;
    run_results(4, 80);
    check("t3_first_grant", grant_cyc_q[0], start + 1);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("t3_id%0d", k), rid_q[k], k);
      check($sformatf("t3_crc%0d", k), rcrc_q[k], crc2(8'(8'h10 * k + 8'h03), 8'(8'h10 * k + 8'h04)));
      check($sformatf("t3_gid%0d", k), grant_id_q[k], k);
      if (k > 0)
        check($sformatf("t3_gap%0d", k), grant_cyc_q[k], acc_cyc_q[k-1] + 2);
    end

    // round-robin past requester 1
    reset_dut();
    load_seq(1, 8'h51, 2);
    drive();
    run_results(1, 30);
    check("t4_first_id", rid_q[0], 1);
    load_seq(0, 8'h61, 2);
    load_seq(3, 8'h71, 2);
    drive();
    run_results(3, 40);
    check("t4_second_id", rid_q[1], 3);
    check("t4_third_id", rid_q[2], 0);
    check("t4_crc3", rcrc_q[1], crc2(8'h71, 8'h72));
    check("t4_crc0", rcrc_q[2], crc2(8'h61, 8'h62));

    // DONE stall with res_ready low
    reset_dut();
    res_ready = 1'b0;
    load_seq(1, 8'h41, 2);
    drive();
    begin
      int k;
      k = 0;
      while (!res_valid && k < 20) begin tick(); k++; end
    end
    check("t5_enter_done", res_valid, 1);
    load_seq(0, 8'h81, 2);
    drive();
    exp = crc2(8'h41, 8'h42);
    for (int k = 0; k < 5; k++) begin
      check("t5_crc", res_crc, exp);
      check("t5_id", res_id, 1);
      check("t5_ready", req_ready, 0);
      check("t5_busy", busy, 1);
      check("t5_valid", res_valid, 1);
      tick();
    end
    res_ready = 1'b1;
    run_results(2, 40);
    check("t5_id_a", rid_q[0], 1);
    check("t5_crc_a", rcrc_q[0], exp);
    check("t5_id_b", rid_q[1], 0);
    check("t5_crc_b", rcrc_q[1], crc2(8'h81, 8'h82));

    // async reset mid-frame, then resend
    reset_dut();
    load_seq(0, 8'h31, 9);
    drive();
    begin
      int k;
      k = 0;
      while (beats_done < 4 && k < 30) begin tick(); k++; end
    end
    check("t6_beats", beats_done, 4);
    check("t6_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_crc", res_crc, 0);
    check("t6_rst_id", res_id, 0);
    fq[0].delete();
    drive();
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b0;
    prev_ready = '0;
    prev_res_valid = 1'b0;
    check("t6_no_stale", valid_rises + rid_q.size(), 0);
    load_seq(0, 8'h31, 9);
    drive();
    run_results(1, 60);
    check("t6_crc", rcrc_q[0], CHECK_VAL);
    check("t6_one_result", valid_rises, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
